// File: rtl/emu_probe_pkg.sv
// Shared types and elaboration helpers for the emulator probe UART readout.
package emu_probe_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA
    } fsm_t;

    function automatic int nbytes(input int width);
        return (width + 7) / 8;
    endfunction

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/emu_probe_uart_tx_byte.sv
// One 8N1 UART byte transmitter; ready rises in the last stop-bit cycle so bytes chain gap-free.
module uart_tx_byte #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int BW = $clog2(DIV);

    logic         active;
    logic [BW-1:0] baud_cnt;
    logic [3:0]   bit_cnt;
    logic [8:0]   shift;
    logic         last_tick;

    assign last_tick = (baud_cnt == BW'(DIV - 1));
    assign ready     = !active || (last_tick && bit_cnt == 4'd9);

    // The shifter back-fills with ones, so the stop bit falls out after the data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '1;
            tx       <= 1'b1;
        end else if (start && ready) begin
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= {1'b1, data};
            tx       <= 1'b0;
        end else if (active) begin
            if (last_tick) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active  <= 1'b0;
                    bit_cnt <= '0;
                    tx      <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    tx      <= shift[0];
                    shift   <= {1'b1, shift[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/emu_probe_uart_tx.sv
// Decimates a signed analog sample stream, queues it and sends each sample as an
// A5-led, sign-extended, MSB-first frame of 8N1 UART bytes.
module emu_probe_uart_tx
    import emu_probe_pkg::*;
#(
    parameter int WIDTH  = 18,
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 8,
    parameter int DECIM  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    input  logic             enable,
    input  logic             clr_ovf,
    output logic             tx,
    output logic             busy,
    output logic             overflow
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD);
    localparam int NB    = nbytes(WIDTH);
    localparam int NBITS = 8 * NB;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int RW    = $clog2(NB + 1);

    if (DIV < 4) begin : g_div_check
        $error("emu_probe_uart_tx: CLK_HZ/BAUD must be at least 4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("emu_probe_uart_tx: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0]        mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;
    logic [DW-1:0]           dec_cnt;
    logic                    empty, full, push_req, push, pop;
    logic signed [WIDTH-1:0] head;

    fsm_t             state, state_d;
    logic [RW-1:0]    rem, rem_d;
    logic [NBITS-1:0] word_q;
    logic             load, shift_word;
    logic             byte_start, byte_ready;
    logic [7:0]       byte_data;

    assign empty    = (count == '0);
    assign full     = (count == (AW + 1)'(DEPTH));
    assign push_req = sample_valid && enable && (dec_cnt == '0);
    assign push     = push_req && (!full || pop);
    assign head     = mem[rd_ptr];
    assign busy     = !empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_cnt <= '0;
        end else if (sample_valid && enable) begin
            dec_cnt <= (dec_cnt == DW'(DECIM - 1)) ? '0 : dec_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem    <= '0;
            word_q <= '0;
        end else begin
            state <= state_d;
            rem   <= rem_d;
            if (load) begin
                word_q <= NBITS'(head);
            end else if (shift_word) begin
                word_q <= word_q << 8;
            end
        end
    end

    always_comb begin
        state_d    = state;
        rem_d      = rem;
        pop        = 1'b0;
        load       = 1'b0;
        shift_word = 1'b0;
        byte_start = 1'b0;
        byte_data  = word_q[NBITS-1 -: 8];
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (byte_ready) begin
                    byte_start = 1'b1;
                    byte_data  = SYNC_BYTE;
                    rem_d      = RW'(NB);
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (byte_ready) begin
                    if (rem != '0) begin
                        byte_start = 1'b1;
                        shift_word = 1'b1;
                        rem_d      = rem - 1'b1;
                    end else if (!empty) begin
                        // Next frame's sync byte starts as the last stop bit ends.
                        pop        = 1'b1;
                        load       = 1'b1;
                        byte_start = 1'b1;
                        byte_data  = SYNC_BYTE;
                        rem_d      = RW'(NB);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_byte (
        .clk   (clk),
        .rst_n (rst_n),
        .start (byte_start),
        .data  (byte_data),
        .tx    (tx),
        .ready (byte_ready)
    );

endmodule

// File: tb/tb_emu_probe_uart_tx.sv
// Bench for emu_probe_uart_tx: a UART decoder feeds a byte scoreboard, plus timing checks.
module tb_emu_probe_uart_tx;

    localparam int WIDTH  = 18;
    localparam int BAUD   = 115200;
    localparam int CLK_HZ = 4 * BAUD;
    localparam int DEPTH  = 4;
    localparam int FRAME_CLKS = 4 * 10 * 4;

    typedef struct {
        logic [WIDTH-1:0] sample;
        logic [23:0]      word;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] sample;
        logic             en;
    } strobe_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [WIDTH-1:0] sample_a, sample_b;
    logic             valid_a, valid_b, enable_a, enable_b, clr_a, clr_b;
    logic             tx_a, busy_a, ovf_a, tx_b, busy_b, ovf_b;

    emu_probe_uart_tx #(
        .WIDTH(WIDTH), .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .DECIM(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_a), .sample_valid(valid_a),
        .enable(enable_a), .clr_ovf(clr_a), .tx(tx_a), .busy(busy_a), .overflow(ovf_a)
    );

    emu_probe_uart_tx #(
        .WIDTH(WIDTH), .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .DECIM(3)
    ) dut_d3 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_b), .sample_valid(valid_b),
        .enable(enable_b), .clr_ovf(clr_b), .tx(tx_b), .busy(busy_b), .overflow(ovf_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         start_times[$];

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic checkByte(input logic [7:0] got, input logic stop);
        logic [7:0] e;
        checkOutput("stop bit", {31'd0, stop}, 32'd1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL unexpected byte: got 0x%0h, expected none (cycle %0d)", got, cyc);
        end else begin
            e = exp_q.pop_front();
            checkOutput("uart byte", {24'd0, got}, {24'd0, e});
        end
    endtask

    // UART decoder on the AND of both lines; only one DUT transmits at a time.
    logic       mon_tx;
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh  = '0;
    logic       mon_stop = 1'b0;
    assign mon_tx = tx_a & tx_b;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (mon_tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                start_times.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt - 2) % 4 == 0)
                mon_sh = {mon_tx, mon_sh[7:1]};
            if (mon_cnt == 38)
                mon_stop = mon_tx;
            if (mon_cnt == 39) begin
                mon_act = 1'b0;
                checkByte(mon_sh, mon_stop);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectFrame(input logic [23:0] word);
        exp_q.push_back(8'hA5);
        exp_q.push_back(word[23:16]);
        exp_q.push_back(word[15:8]);
        exp_q.push_back(word[7:0]);
    endtask

    task automatic applyStimulus(input int ch, input logic [WIDTH-1:0] v);
        if (ch == 0) begin
            sample_a = v;
            valid_a  = 1'b1;
        end else begin
            sample_b = v;
            valid_b  = 1'b1;
        end
        tick();
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic waitIdle(input int ch, input int max_clks, output int n);
        n = 0;
        while (((ch == 0) ? busy_a : busy_b) !== 1'b0) begin
            if (n >= max_clks) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL idle timeout: busy still 1 after %0d clks, expected 0", n);
                return;
            end
            tick();
            n++;
        end
    endtask

    vec_t    vecs[6];
    strobe_t strobes[10];
    int      n;
    int      dcnt;

    initial begin
        vecs[0] = '{18'h0_2001, 24'h002001};
        vecs[1] = '{18'h3_FFFF, 24'hFFFFFF};
        vecs[2] = '{18'h2_0001, 24'hFE0001};
        vecs[3] = '{18'h1_FFFF, 24'h01FFFF};
        vecs[4] = '{18'h2_0000, 24'hFE0000};
        vecs[5] = '{18'h0_0000, 24'h000000};

        strobes[0] = '{18'd0, 1'b1};
        strobes[1] = '{18'd1, 1'b1};
        strobes[2] = '{18'd2, 1'b1};
        strobes[3] = '{18'd99, 1'b0};
        strobes[4] = '{18'd3, 1'b1};
        strobes[5] = '{18'd4, 1'b1};
        strobes[6] = '{18'd5, 1'b1};
        strobes[7] = '{18'd6, 1'b1};
        strobes[8] = '{18'd7, 1'b1};
        strobes[9] = '{18'd8, 1'b1};

        rst_n    = 1'b0;
        sample_a = '0;
        sample_b = '0;
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        enable_a = 1'b1;
        enable_b = 1'b1;
        clr_a    = 1'b0;
        clr_b    = 1'b0;

        // Reset with strobes toggling: nothing may be captured.
        for (int i = 0; i < 5; i++) begin
            valid_a  = i[0];
            sample_a = 18'h1_5555;
            tick();
            checkOutput("reset tx", {31'd0, tx_a}, 32'd1);
        end
        checkOutput("reset busy", {31'd0, busy_a}, 32'd0);
        checkOutput("reset overflow", {31'd0, ovf_a}, 32'd0);
        valid_a = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("post-reset no start", 32'(start_times.size()), 32'd0);
        checkOutput("post-reset busy", {31'd0, busy_a}, 32'd0);

        $display("[TB] single-sample frames");
        for (int i = 0; i < 6; i++) begin
            expectFrame(vecs[i].word);
            applyStimulus(0, vecs[i].sample);
            sample_a = ~vecs[i].sample;
            tick();
            checkOutput("latency tx idle at +1", {31'd0, tx_a}, 32'd1);
            tick();
            checkOutput("latency start at +2", {31'd0, tx_a}, 32'd0);
            waitIdle(0, 400, n);
            checkOutput("frame length", 32'(n), 32'(FRAME_CLKS));
            checkOutput("bytes outstanding", 32'(exp_q.size()), 32'd0);
        end

        $display("[TB] overflow burst");
        start_times.delete();
        for (int i = 1; i <= 5; i++) expectFrame(24'(i));
        for (int i = 1; i <= 6; i++) begin
            sample_a = 18'(i);
            valid_a  = 1'b1;
            tick();
        end
        valid_a = 1'b0;
        checkOutput("overflow set", {31'd0, ovf_a}, 32'd1);
        waitIdle(0, 5 * FRAME_CLKS + 50, n);
        checkOutput("overflow sticky", {31'd0, ovf_a}, 32'd1);
        checkOutput("burst byte count", 32'(start_times.size()), 32'd20);
        if (start_times.size() == 20)
            checkOutput("burst no gaps", 32'(start_times[19] - start_times[0]), 32'd760);
        checkOutput("burst outstanding", 32'(exp_q.size()), 32'd0);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        checkOutput("overflow cleared", {31'd0, ovf_a}, 32'd0);

        $display("[TB] decimation by 3");
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (strobes[i].en) begin
                if (dcnt == 0) expectFrame(24'(strobes[i].sample));
                dcnt = (dcnt + 1) % 3;
            end
            enable_b = strobes[i].en;
            applyStimulus(1, strobes[i].sample);
        end
        enable_b = 1'b1;
        waitIdle(1, 4 * FRAME_CLKS, n);
        checkOutput("decim outstanding", 32'(exp_q.size()), 32'd0);
        checkOutput("decim no overflow", {31'd0, ovf_b}, 32'd0);

        $display("[TB] reset mid-frame");
        exp_q.push_back(8'hA5);
        applyStimulus(0, 18'h0_1234);
        for (int i = 0; i < 60; i++) tick();
        rst_n = 1'b0;
        tick();
        checkOutput("mid-frame reset tx", {31'd0, tx_a}, 32'd1);
        checkOutput("mid-frame reset busy", {31'd0, busy_a}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("sync delivered before reset", 32'(exp_q.size()), 32'd0);
        expectFrame(24'h000042);
        applyStimulus(0, 18'h0_0042);
        waitIdle(0, 400, n);
        checkOutput("clean frame after reset", 32'(exp_q.size()), 32'd0);

        for (int i = 0; i < 5; i++) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
